// File: rtl/alu.sv
// 8-bit 6502-style ALU: one op per cycle chosen by one-hot enables, with registered
// result, carry and signed overflow. Operand B can be inverted so SUM can subtract.
module alu (
  input  logic       clk,
  input  logic       reset,
  input  logic       SUM_en,
  input  logic       AND_en,
  input  logic       EOR_en,
  input  logic       OR_en,
  input  logic       ASL_en,
  input  logic       LSR_en,
  input  logic       INV_en,
  input  logic       ROL_en,
  input  logic       ROR_en,
  input  logic [7:0] Ain,
  input  logic [7:0] Bin,
  input  logic       Cin,
  output logic [7:0] RES,
  output logic       Cout,
  output logic       OVFout
);

  logic [7:0] r_res;
  logic       r_cout;
  logic       r_ovf;

  logic [7:0] w_b;
  logic [8:0] w_sum;
  logic [7:0] w_res;
  logic       w_cout;
  logic       w_ovf;

  assign w_b   = INV_en ? ~Bin : Bin;
  assign w_sum = {1'b0, Ain} + {1'b0, w_b} + {8'h00, Cin};

  // Priority chain; with no enable at all the registers simply reload themselves.
  always_comb begin
    w_res  = r_res;
    w_cout = r_cout;
    w_ovf  = r_ovf;
    if (SUM_en) begin
      w_res  = w_sum[7:0];
      w_cout = w_sum[8];
      w_ovf  = (Ain[7] == w_b[7]) && (w_sum[7] != Ain[7]);
    end else if (AND_en) begin
      w_res  = Ain & w_b;
      w_cout = 1'b0;
      w_ovf  = 1'b0;
    end else if (EOR_en) begin
      w_res  = Ain ^ w_b;
      w_cout = 1'b0;
      w_ovf  = 1'b0;
    end else if (OR_en) begin
      w_res  = Ain | w_b;
      w_cout = 1'b0;
      w_ovf  = 1'b0;
    end else if (ASL_en) begin
      w_res  = {Ain[6:0], 1'b0};
      w_cout = Ain[7];
      w_ovf  = 1'b0;
    end else if (LSR_en) begin
      w_res  = {1'b0, Ain[7:1]};
      w_cout = Ain[0];
      w_ovf  = 1'b0;
    end else if (ROL_en) begin
      w_res  = {Ain[6:0], Cin};
      w_cout = Ain[7];
      w_ovf  = 1'b0;
    end else if (ROR_en) begin
      w_res  = {Cin, Ain[7:1]};
      w_cout = Ain[0];
      w_ovf  = 1'b0;
    end else if (INV_en) begin
      // Inverter alone passes ~Bin straight through.
      w_res  = w_b;
      w_cout = 1'b0;
      w_ovf  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res  <= 8'h00;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_res  <= w_res;
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
    end
  end

  assign RES    = r_res;
  assign Cout   = r_cout;
  assign OVFout = r_ovf;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed cases plus random ops checked against an arithmetic model.
module tb_alu;
  logic       clk = 1'b0;
  logic       reset;
  logic       SUM_en, AND_en, EOR_en, OR_en, ASL_en, LSR_en, INV_en, ROL_en, ROR_en;
  logic [7:0] Ain, Bin;
  logic       Cin;
  logic [7:0] RES;
  logic       Cout, OVFout;

  int total = 0;
  int bad   = 0;

  // model state: {res, c, v}
  int m_res, m_c, m_v;

  alu dut (
    .clk(clk), .reset(reset),
    .SUM_en(SUM_en), .AND_en(AND_en), .EOR_en(EOR_en), .OR_en(OR_en),
    .ASL_en(ASL_en), .LSR_en(LSR_en), .INV_en(INV_en), .ROL_en(ROL_en), .ROR_en(ROR_en),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .RES(RES), .Cout(Cout), .OVFout(OVFout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got res=%02h c=%0b v=%0b, expected res=%02h c=%0b v=%0b",
               tag, got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
    end
  endtask

  // Reference: en = {SUM,AND,EOR,OR,ASL,LSR,INV,ROL,ROR}; integer arithmetic on the rules.
  task automatic model(input logic [8:0] en, input int a, input int b, input int ci);
    int bp, s, sa, sb;
    bp = en[2] ? (255 - b) : b;
    if (en[8]) begin
      s  = a + bp + ci;
      sa = (a  > 127) ? a  - 256 : a;
      sb = (bp > 127) ? bp - 256 : bp;
      m_res = s % 256;
      m_c   = (s > 255) ? 1 : 0;
      m_v   = ((sa + sb + ci) > 127 || (sa + sb + ci) < -128) ? 1 : 0;
    end else if (en[7]) begin m_res = a & bp; m_c = 0; m_v = 0; end
    else if (en[6]) begin m_res = a ^ bp; m_c = 0; m_v = 0; end
    else if (en[5]) begin m_res = a | bp; m_c = 0; m_v = 0; end
    else if (en[4]) begin m_res = (a * 2) % 256;      m_c = a / 128; m_v = 0; end
    else if (en[3]) begin m_res = a / 2;              m_c = a % 2;   m_v = 0; end
    else if (en[1]) begin m_res = (a * 2) % 256 + ci; m_c = a / 128; m_v = 0; end
    else if (en[0]) begin m_res = a / 2 + ci * 128;   m_c = a % 2;   m_v = 0; end
    else if (en[2]) begin m_res = 255 - b; m_c = 0; m_v = 0; end
  endtask

  function automatic logic [9:0] mexp();
    return {m_res[7:0], m_c[0], m_v[0]};
  endfunction

  task automatic drive(input logic [8:0] en, input logic [7:0] a, input logic [7:0] b,
                       input logic ci);
    {SUM_en, AND_en, EOR_en, OR_en, ASL_en, LSR_en, INV_en, ROL_en, ROR_en} = en;
    Ain = a; Bin = b; Cin = ci;
  endtask

  // apply one op on a negedge, check one edge later
  task automatic op(input string tag, input logic [8:0] en, input logic [7:0] a,
                    input logic [7:0] b, input logic ci);
    @(negedge clk);
    drive(en, a, b, ci);
    model(en, int'(a), int'(b), int'(ci));
    @(posedge clk);
    #1;
    chk(tag, {RES, Cout, OVFout}, mexp());
  endtask

  localparam logic [8:0] E_SUM = 9'b100000000, E_AND = 9'b010000000, E_EOR = 9'b001000000,
                         E_OR  = 9'b000100000, E_ASL = 9'b000010000, E_LSR = 9'b000001000,
                         E_INV = 9'b000000100, E_ROL = 9'b000000010, E_ROR = 9'b000000001,
                         E_NONE = 9'b0;

  initial begin
    logic [8:0] en;
    reset = 1'b1;
    drive(E_NONE, 8'h00, 8'h00, 1'b0);
    m_res = 0; m_c = 0; m_v = 0;
    #12;
    chk("reset", {RES, Cout, OVFout}, 10'h000);
    @(negedge clk);
    reset = 1'b0;

    // directed cases with hand-derived expectations
    op("asl", E_ASL, 8'hAA, 8'h00, 1'b1); chk("asl_k", {RES, Cout, OVFout}, {8'h54, 2'b10});
    op("lsr", E_LSR, 8'hAA, 8'h00, 1'b1); chk("lsr_k", {RES, Cout, OVFout}, {8'h55, 2'b00});
    op("rol", E_ROL, 8'hAA, 8'h00, 1'b1); chk("rol_k", {RES, Cout, OVFout}, {8'h55, 2'b10});
    op("ror", E_ROR, 8'hAA, 8'h00, 1'b1); chk("ror_k", {RES, Cout, OVFout}, {8'hD5, 2'b00});
    op("add_v", E_SUM, 8'h50, 8'h50, 1'b0); chk("add_v_k", {RES, Cout, OVFout}, {8'hA0, 2'b01});
    op("add_c", E_SUM, 8'hFF, 8'h01, 1'b0); chk("add_c_k", {RES, Cout, OVFout}, {8'h00, 2'b10});
    op("sub", E_SUM | E_INV, 8'h50, 8'hF0, 1'b1);
    chk("sub_k", {RES, Cout, OVFout}, {8'h60, 2'b00});
    op("and_or", E_AND | E_OR, 8'hF0, 8'h3C, 1'b0);
    chk("and_or_k", {RES, Cout, OVFout}, {8'h30, 2'b00});
    op("eor", E_EOR, 8'hF0, 8'h3C, 1'b0); chk("eor_k", {RES, Cout, OVFout}, {8'hCC, 2'b00});
    op("inv", E_INV, 8'hF0, 8'h3C, 1'b0); chk("inv_k", {RES, Cout, OVFout}, {8'hC3, 2'b00});
    op("asl_c", E_ASL, 8'h80, 8'h00, 1'b0);
    op("hold", E_NONE, 8'h12, 8'h34, 1'b1); chk("hold_k", {RES, Cout, OVFout}, {8'h00, 2'b10});
    op("hold2", E_NONE, 8'hFF, 8'hFF, 1'b0);

    // asynchronous reset mid-cycle, then first op lands one edge after release
    op("pre_rst", E_SUM, 8'h7F, 8'h01, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst", {RES, Cout, OVFout}, 10'h000);
    drive(E_SUM, 8'hFF, 8'hFF, 1'b1);
    @(posedge clk); #1;
    chk("rst_held", {RES, Cout, OVFout}, 10'h000);
    m_res = 0; m_c = 0; m_v = 0;
    @(negedge clk);
    reset = 1'b0;
    op("post_rst", E_SUM, 8'h01, 8'h02, 1'b1);

    // random: each enable ~1/4 likely so priorities, INV-alone and hold all occur
    for (int i = 0; i < 400; i++) begin
      en = '0;
      for (int k = 0; k < 9; k++) en[k] = ($urandom_range(0, 3) == 0);
      op("rand", en, 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
